// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, functs,
// FSM states, output select codes and the decoded-instruction record.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BGEZ  = 6'h01;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_MULT = 6'h18;
   localparam logic [5:0] F_DIV  = 6'h1A;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_SLT  = 6'h2A;

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_EX      = 4'd2,
      S_EX_BR   = 4'd3,
      S_EX_ADDR = 4'd4,
      S_MEM     = 4'd5,
      S_WB_ALU  = 4'd6,
      S_WB_MEM  = 4'd7,
      S_EX_MD   = 4'd8,
      S_TRAP    = 4'd9
   } state_t;

   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_BGEZ = 4'd4;
   localparam logic [3:0] ALU_AND  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_XOR  = 4'd7;
   localparam logic [3:0] ALU_MULT = 4'd8;
   localparam logic [3:0] ALU_DIV  = 4'd9;

   localparam logic [2:0] NPC_SEQ  = 3'd0;
   localparam logic [2:0] NPC_JUMP = 3'd1;
   localparam logic [2:0] NPC_BR   = 3'd3;
   localparam logic [2:0] NPC_JR   = 3'd4;
   localparam logic [2:0] NPC_TRAP = 3'd5;

   localparam logic [1:0] EXT_LUI  = 2'd0;
   localparam logic [1:0] EXT_ZERO = 2'd1;
   localparam logic [1:0] EXT_SIGN = 2'd2;

   localparam logic [1:0] RD_RT  = 2'd0;
   localparam logic [1:0] RD_RD  = 2'd1;
   localparam logic [1:0] RD_R31 = 2'd3;

   localparam logic [2:0] WBS_ALU = 3'd0;
   localparam logic [2:0] WBS_DM  = 3'd1;
   localparam logic [2:0] WBS_MD  = 3'd2;
   localparam logic [2:0] WBS_LUI = 3'd3;
   localparam logic [2:0] WBS_PC  = 3'd4;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_ILL  = 2'd1;
   localparam logic [1:0] CAUSE_IMEM = 2'd2;
   localparam logic [1:0] CAUSE_DMEM = 2'd3;

   typedef enum logic [2:0] {
      C_ALU, C_MEM, C_BR, C_J, C_JAL, C_JR, C_MD
   } iclass_t;

   typedef struct packed {
      iclass_t    cls;
      logic       illegal;
      logic       is_sw;
      logic       is_beq;
      logic       is_bgez;
      logic       is_bgtz;
      logic [1:0] ext_op;
      logic [1:0] regdst;
      logic [2:0] wbsrc;
      logic       alusrc;
      logic [3:0] alu;
   } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/funct to instruction class, illegal flag
// and the datapath selects that follow the instruction through every state.
module mc_decode
   import mc_ctrl_pkg::*;
#(
   parameter int ENABLE_MD = 1
) (
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec        = '0;
      dec.cls    = C_ALU;
      dec.ext_op = EXT_SIGN;
      dec.regdst = RD_RT;
      dec.wbsrc  = WBS_ALU;
      dec.alu    = ALU_NOP;
      case (op)
         OP_RTYPE: begin
            dec.regdst = RD_RD;
            case (funct)
               F_ADD:  dec.alu = ALU_ADD;
               F_SUB:  dec.alu = ALU_SUB;
               F_OR:   dec.alu = ALU_OR;
               F_AND:  dec.alu = ALU_AND;
               F_SLT:  dec.alu = ALU_SLT;
               F_XOR:  dec.alu = ALU_XOR;
               F_JR:   dec.cls = C_JR;
               F_MULT: begin
                  if (ENABLE_MD != 0) begin
                     dec.cls = C_MD;
                     dec.alu = ALU_MULT;
                  end else begin
                     dec.illegal = 1'b1;
                  end
               end
               F_DIV: begin
                  if (ENABLE_MD != 0) begin
                     dec.cls = C_MD;
                     dec.alu = ALU_DIV;
                  end else begin
                     dec.illegal = 1'b1;
                  end
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin
            dec.alusrc = 1'b1;
            dec.alu    = ALU_ADD;
         end
         OP_ORI: begin
            dec.alusrc = 1'b1;
            dec.ext_op = EXT_ZERO;
            dec.alu    = ALU_OR;
         end
         OP_LUI: begin
            dec.alusrc = 1'b1;
            dec.ext_op = EXT_LUI;
            dec.wbsrc  = WBS_LUI;
         end
         OP_LW: begin
            dec.cls    = C_MEM;
            dec.alusrc = 1'b1;
            dec.wbsrc  = WBS_DM;
            dec.alu    = ALU_ADD;
         end
         OP_SW: begin
            dec.cls    = C_MEM;
            dec.is_sw  = 1'b1;
            dec.alusrc = 1'b1;
            dec.alu    = ALU_ADD;
         end
         OP_BEQ: begin
            dec.cls    = C_BR;
            dec.is_beq = 1'b1;
            dec.alu    = ALU_SUB;
         end
         OP_BGEZ: begin
            dec.cls     = C_BR;
            dec.is_bgez = 1'b1;
            dec.alu     = ALU_BGEZ;
         end
         OP_BGTZ: begin
            dec.cls     = C_BR;
            dec.is_bgtz = 1'b1;
            dec.alu     = ALU_BGEZ;
         end
         OP_J:    dec.cls = C_J;
         OP_JAL: begin
            dec.cls    = C_JAL;
            dec.regdst = RD_R31;
            dec.wbsrc  = WBS_PC;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM with imem/dmem handshakes, mult/div wait and a trap
// path for illegal instructions and memory-ack timeouts.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int ALUCTR_W    = 5,
   parameter int ENABLE_MD   = 1,
   parameter int MEM_TIMEOUT = 16,
   parameter int TIMER_W     = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                beqout,
   input  logic                bgezout,
   input  logic                imem_ack,
   input  logic                dmem_ack,
   input  logic                md_done,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                pc_we,
   output logic                ir_we,
   output logic                reg_we,
   output logic                md_start,
   output logic [ALUCTR_W-1:0] alu_ctr,
   output logic [2:0]          npc_sel,
   output logic [1:0]          ext_op,
   output logic [1:0]          regdst_sel,
   output logic [2:0]          wbsrc_sel,
   output logic                alusrc_sel,
   output logic                trap,
   output logic [1:0]          cause,
   output logic [3:0]          state_out
);

   localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(MEM_TIMEOUT - 1);

   state_t             state, state_n;
   logic [TIMER_W-1:0] cnt, cnt_n;
   logic [1:0]         cause_q, trap_cause;
   logic               timeout, br_taken;
   dec_t               dec;

   mc_decode #(.ENABLE_MD(ENABLE_MD)) u_decode (
      .op    (op),
      .funct (funct),
      .dec   (dec)
   );

   assign timeout  = (MEM_TIMEOUT > 0) && (cnt == TO_LAST);
   assign br_taken = (dec.is_beq & beqout) | (dec.is_bgez & bgezout) |
                     (dec.is_bgtz & bgezout & ~beqout);

   // Only IF and MEM ever stay put while waiting on an ack, so any state change clears the count.
   assign cnt_n = (state_n == state && (state == S_IF || state == S_MEM)) ?
                  cnt + TIMER_W'(1) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IF;
         cnt     <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (trap_cause != CAUSE_NONE) cause_q <= trap_cause;
      end
   end

   always_comb begin
      state_n    = state;
      trap_cause = CAUSE_NONE;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      md_start   = 1'b0;
      trap       = 1'b0;
      alu_ctr    = '0;
      npc_sel    = NPC_SEQ;
      ext_op     = dec.ext_op;
      regdst_sel = dec.regdst;
      wbsrc_sel  = dec.wbsrc;
      alusrc_sel = dec.alusrc;
      cause      = cause_q;
      state_out  = state;
      case (state)
         S_IF: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_n = S_ID;
            end else if (timeout) begin
               state_n    = S_TRAP;
               trap_cause = CAUSE_IMEM;
            end
         end
         S_ID: begin
            if (dec.illegal) begin
               state_n    = S_TRAP;
               trap_cause = CAUSE_ILL;
            end else begin
               case (dec.cls)
                  C_J: begin
                     pc_we   = 1'b1;
                     npc_sel = NPC_JUMP;
                     state_n = S_IF;
                  end
                  C_JAL: begin
                     pc_we   = 1'b1;
                     npc_sel = NPC_JUMP;
                     reg_we  = 1'b1;
                     state_n = S_IF;
                  end
                  C_JR: begin
                     pc_we   = 1'b1;
                     npc_sel = NPC_JR;
                     state_n = S_IF;
                  end
                  C_MEM: state_n = S_EX_ADDR;
                  C_BR:  state_n = S_EX_BR;
                  C_MD: begin
                     md_start = 1'b1;
                     state_n  = S_EX_MD;
                  end
                  default: state_n = S_EX;
               endcase
            end
         end
         S_EX: begin
            alu_ctr = ALUCTR_W'(dec.alu);
            state_n = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_we  = 1'b1;
            state_n = S_IF;
         end
         S_EX_BR: begin
            alu_ctr = ALUCTR_W'(dec.alu);
            if (br_taken) begin
               pc_we   = 1'b1;
               npc_sel = NPC_BR;
            end
            state_n = S_IF;
         end
         S_EX_ADDR: begin
            alu_ctr    = ALUCTR_W'(ALU_ADD);
            alusrc_sel = 1'b1;
            ext_op     = EXT_SIGN;
            state_n    = S_MEM;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = dec.is_sw;
            if (dmem_ack) begin
               state_n = dec.is_sw ? S_IF : S_WB_MEM;
            end else if (timeout) begin
               state_n    = S_TRAP;
               trap_cause = CAUSE_DMEM;
            end
         end
         S_WB_MEM: begin
            reg_we     = 1'b1;
            wbsrc_sel  = WBS_DM;
            regdst_sel = RD_RT;
            state_n    = S_IF;
         end
         S_EX_MD: begin
            alu_ctr = ALUCTR_W'(dec.alu);
            if (md_done) state_n = S_IF;
         end
         S_TRAP: begin
            trap    = 1'b1;
            pc_we   = 1'b1;
            npc_sel = NPC_TRAP;
            state_n = S_IF;
         end
         default: state_n = S_IF;
      endcase
      // Reset forces every output low, including the IF fetch request.
      if (rst) begin
         imem_req   = 1'b0;
         dmem_req   = 1'b0;
         dmem_we    = 1'b0;
         pc_we      = 1'b0;
         ir_we      = 1'b0;
         reg_we     = 1'b0;
         md_start   = 1'b0;
         trap       = 1'b0;
         alu_ctr    = '0;
         npc_sel    = '0;
         ext_op     = '0;
         regdst_sel = '0;
         wbsrc_sel  = '0;
         alusrc_sel = 1'b0;
         cause      = '0;
         state_out  = '0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed table-driven bench for mc_ctrl_fsm plus hand sequences for mult/div,
// ENABLE_MD=0 decode and reset asserted in the middle of a data-memory access.
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic [7:0] stb;   // imem_req dmem_req dmem_we pc_we ir_we reg_we md_start trap
      logic [4:0] alu;
      logic [2:0] npc;
      logic [7:0] dsel;  // regdst(2) wbsrc(3) ext_op(2) alusrc(1)
      logic [1:0] ca;
   } obs_t;

   typedef struct {
      string      nm;
      logic [5:0] op;
      logic [5:0] funct;
      logic [4:0] in;    // beqout bgezout imem_ack dmem_ack md_done
      obs_t       exp;
   } vec_t;

   localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_EX = 4'd2, ST_BR = 4'd3,
                          ST_AD = 4'd4, ST_MEM = 4'd5, ST_WBA = 4'd6, ST_WBM = 4'd7,
                          ST_MD = 4'd8, ST_TRAP = 4'd9;
   localparam logic [4:0] I_NONE = 5'b00000, I_IA = 5'b00100, I_DA = 5'b00010,
                          I_BQ = 5'b10000, I_BG = 5'b01000, I_BGBQ = 5'b11000;
   localparam logic [7:0] B_NONE = 8'b0000_0000, B_IFW = 8'b1000_0000,
                          B_IFA = 8'b1001_1000, B_WB = 8'b0000_0100,
                          B_RD = 8'b0100_0000, B_WR = 8'b0110_0000,
                          B_PC = 8'b0001_0000, B_JAL = 8'b0001_0100,
                          B_TRAP = 8'b0001_0001, B_MDS = 8'b0000_0010;
   localparam logic [7:0] D_ADD = {2'd1, 3'd0, 2'd2, 1'b0};
   localparam logic [7:0] D_LW  = {2'd0, 3'd1, 2'd2, 1'b1};
   localparam logic [7:0] D_SW  = {2'd0, 3'd0, 2'd2, 1'b1};
   localparam logic [7:0] D_BR  = {2'd0, 3'd0, 2'd2, 1'b0};
   localparam logic [7:0] D_JAL = {2'd3, 3'd4, 2'd2, 1'b0};
   localparam logic [5:0] OP_BAD = 6'h3F;

   logic clk, rst;
   logic [5:0] op, funct;
   logic beqout, bgezout, imem_ack, dmem_ack, md_done;

   logic imr_a, dmr_a, dmw_a, pcw_a, irw_a, rgw_a, mds_a, trp_a, as_a;
   logic [4:0] alu_a;
   logic [2:0] npc_a, wb_a;
   logic [1:0] ex_a, rd_a, ca_a;
   logic [3:0] st_a;
   logic imr_b, dmr_b, dmw_b, pcw_b, irw_b, rgw_b, mds_b, trp_b, as_b;
   logic [4:0] alu_b;
   logic [2:0] npc_b, wb_b;
   logic [1:0] ex_b, rd_b, ca_b;
   logic [3:0] st_b;
   obs_t obs_a, obs_b;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   mc_ctrl_fsm #(.ALUCTR_W(5), .ENABLE_MD(1), .MEM_TIMEOUT(4), .TIMER_W(3)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .beqout(beqout), .bgezout(bgezout),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .md_done(md_done),
      .imem_req(imr_a), .dmem_req(dmr_a), .dmem_we(dmw_a), .pc_we(pcw_a), .ir_we(irw_a),
      .reg_we(rgw_a), .md_start(mds_a), .alu_ctr(alu_a), .npc_sel(npc_a), .ext_op(ex_a),
      .regdst_sel(rd_a), .wbsrc_sel(wb_a), .alusrc_sel(as_a), .trap(trp_a), .cause(ca_a),
      .state_out(st_a)
   );

   mc_ctrl_fsm #(.ALUCTR_W(5), .ENABLE_MD(0), .MEM_TIMEOUT(4), .TIMER_W(3)) dut_nomd (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .beqout(beqout), .bgezout(bgezout),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .md_done(md_done),
      .imem_req(imr_b), .dmem_req(dmr_b), .dmem_we(dmw_b), .pc_we(pcw_b), .ir_we(irw_b),
      .reg_we(rgw_b), .md_start(mds_b), .alu_ctr(alu_b), .npc_sel(npc_b), .ext_op(ex_b),
      .regdst_sel(rd_b), .wbsrc_sel(wb_b), .alusrc_sel(as_b), .trap(trp_b), .cause(ca_b),
      .state_out(st_b)
   );

   assign obs_a = {st_a, imr_a, dmr_a, dmw_a, pcw_a, irw_a, rgw_a, mds_a, trp_a,
                   alu_a, npc_a, rd_a, wb_a, ex_a, as_a, ca_a};
   assign obs_b = {st_b, imr_b, dmr_b, dmw_b, pcw_b, irw_b, rgw_b, mds_b, trp_b,
                   alu_b, npc_b, rd_b, wb_b, ex_b, as_b, ca_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(logic [3:0] st, logic [7:0] stb, logic [4:0] alu,
                               logic [2:0] npc, logic [7:0] dsel, logic [1:0] ca);
      obs_t o;
      o.st = st; o.stb = stb; o.alu = alu; o.npc = npc; o.dsel = dsel; o.ca = ca;
      return o;
   endfunction

   function automatic vec_t row(string nm, logic [5:0] o, logic [5:0] f, logic [4:0] in,
                                logic [3:0] st, logic [7:0] stb, logic [4:0] alu,
                                logic [2:0] npc, logic [7:0] dsel, logic [1:0] ca);
      vec_t v;
      v.nm = nm; v.op = o; v.funct = f; v.in = in;
      v.exp = mk(st, stb, alu, npc, dsel, ca);
      return v;
   endfunction

   task automatic check_obs(string nm, obs_t got, obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d stb=%b alu=%0d npc=%0d dsel=%b ca=%0d, expected st=%0d stb=%b alu=%0d npc=%0d dsel=%b ca=%0d",
                  nm, got.st, got.stb, got.alu, got.npc, got.dsel, got.ca,
                  exp.st, exp.stb, exp.alu, exp.npc, exp.dsel, exp.ca);
      end
   endtask

   task automatic drive(logic [5:0] o, logic [5:0] f, logic [4:0] in);
      op = o; funct = f;
      {beqout, bgezout, imem_ack, dmem_ack, md_done} = in;
   endtask

   initial begin
      rst = 1'b1;
      drive(OP_RTYPE, F_ADD, I_IA | I_DA);

      vecs.push_back(row("add_if0",  OP_RTYPE, F_ADD, I_NONE, ST_IF,  B_IFW,  5'd0, 3'd0, D_ADD, 2'd0));
      vecs.push_back(row("add_if1",  OP_RTYPE, F_ADD, I_NONE, ST_IF,  B_IFW,  5'd0, 3'd0, D_ADD, 2'd0));
      vecs.push_back(row("add_ifa",  OP_RTYPE, F_ADD, I_IA,   ST_IF,  B_IFA,  5'd0, 3'd0, D_ADD, 2'd0));
      vecs.push_back(row("add_id",   OP_RTYPE, F_ADD, I_NONE, ST_ID,  B_NONE, 5'd0, 3'd0, D_ADD, 2'd0));
      vecs.push_back(row("add_ex",   OP_RTYPE, F_ADD, I_NONE, ST_EX,  B_NONE, 5'd1, 3'd0, D_ADD, 2'd0));
      vecs.push_back(row("add_wb",   OP_RTYPE, F_ADD, I_NONE, ST_WBA, B_WB,   5'd0, 3'd0, D_ADD, 2'd0));
      vecs.push_back(row("lw_if",    OP_LW, 6'h00, I_IA,   ST_IF,  B_IFA,  5'd0, 3'd0, D_LW, 2'd0));
      vecs.push_back(row("lw_id",    OP_LW, 6'h00, I_NONE, ST_ID,  B_NONE, 5'd0, 3'd0, D_LW, 2'd0));
      vecs.push_back(row("lw_exa",   OP_LW, 6'h00, I_NONE, ST_AD,  B_NONE, 5'd1, 3'd0, D_LW, 2'd0));
      vecs.push_back(row("lw_mem",   OP_LW, 6'h00, I_DA,   ST_MEM, B_RD,   5'd0, 3'd0, D_LW, 2'd0));
      vecs.push_back(row("lw_wbm",   OP_LW, 6'h00, I_NONE, ST_WBM, B_WB,   5'd0, 3'd0, D_LW, 2'd0));
      vecs.push_back(row("sw_if",    OP_SW, 6'h00, I_IA,   ST_IF,  B_IFA,  5'd0, 3'd0, D_SW, 2'd0));
      vecs.push_back(row("sw_id",    OP_SW, 6'h00, I_NONE, ST_ID,  B_NONE, 5'd0, 3'd0, D_SW, 2'd0));
      vecs.push_back(row("sw_exa",   OP_SW, 6'h00, I_NONE, ST_AD,  B_NONE, 5'd1, 3'd0, D_SW, 2'd0));
      vecs.push_back(row("sw_memw",  OP_SW, 6'h00, I_NONE, ST_MEM, B_WR,   5'd0, 3'd0, D_SW, 2'd0));
      vecs.push_back(row("sw_mema",  OP_SW, 6'h00, I_DA,   ST_MEM, B_WR,   5'd0, 3'd0, D_SW, 2'd0));
      vecs.push_back(row("beq1_if",  OP_BEQ, 6'h00, I_IA,   ST_IF, B_IFA,  5'd0, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("beq1_id",  OP_BEQ, 6'h00, I_NONE, ST_ID, B_NONE, 5'd0, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("beq1_tk",  OP_BEQ, 6'h00, I_BQ,   ST_BR, B_PC,   5'd2, 3'd3, D_BR, 2'd0));
      vecs.push_back(row("beq2_if",  OP_BEQ, 6'h00, I_IA,   ST_IF, B_IFA,  5'd0, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("beq2_id",  OP_BEQ, 6'h00, I_NONE, ST_ID, B_NONE, 5'd0, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("beq2_nt",  OP_BEQ, 6'h00, I_NONE, ST_BR, B_NONE, 5'd2, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("bgez_if",  OP_BGEZ, 6'h00, I_IA,   ST_IF, B_IFA,  5'd0, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("bgez_id",  OP_BGEZ, 6'h00, I_NONE, ST_ID, B_NONE, 5'd0, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("bgez_tk",  OP_BGEZ, 6'h00, I_BG,   ST_BR, B_PC,   5'd4, 3'd3, D_BR, 2'd0));
      vecs.push_back(row("bgtz_if",  OP_BGTZ, 6'h00, I_IA,   ST_IF, B_IFA,  5'd0, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("bgtz_id",  OP_BGTZ, 6'h00, I_NONE, ST_ID, B_NONE, 5'd0, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("bgtz_zro", OP_BGTZ, 6'h00, I_BGBQ, ST_BR, B_NONE, 5'd4, 3'd0, D_BR, 2'd0));
      vecs.push_back(row("jal_if",   OP_JAL, 6'h00, I_IA,   ST_IF, B_IFA,  5'd0, 3'd0, D_JAL, 2'd0));
      vecs.push_back(row("jal_id",   OP_JAL, 6'h00, I_NONE, ST_ID, B_JAL,  5'd0, 3'd1, D_JAL, 2'd0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(row($sformatf("ito_if%0d", i), OP_RTYPE, F_ADD, I_NONE, ST_IF, B_IFW, 5'd0, 3'd0, D_ADD, 2'd0));
      vecs.push_back(row("ito_trap", OP_RTYPE, F_ADD, I_NONE, ST_TRAP, B_TRAP, 5'd0, 3'd5, D_ADD, 2'd2));
      for (int i = 0; i < 3; i++)
         vecs.push_back(row($sformatf("late_if%0d", i), OP_BAD, 6'h00, I_NONE, ST_IF, B_IFW, 5'd0, 3'd0, D_BR, 2'd2));
      vecs.push_back(row("late_ack", OP_BAD, 6'h00, I_IA,   ST_IF,   B_IFA,  5'd0, 3'd0, D_BR, 2'd2));
      vecs.push_back(row("ill_id",   OP_BAD, 6'h00, I_NONE, ST_ID,   B_NONE, 5'd0, 3'd0, D_BR, 2'd2));
      vecs.push_back(row("ill_trap", OP_BAD, 6'h00, I_NONE, ST_TRAP, B_TRAP, 5'd0, 3'd5, D_BR, 2'd1));
      vecs.push_back(row("dto_if",   OP_LW, 6'h00, I_IA,   ST_IF, B_IFA,  5'd0, 3'd0, D_LW, 2'd1));
      vecs.push_back(row("dto_id",   OP_LW, 6'h00, I_NONE, ST_ID, B_NONE, 5'd0, 3'd0, D_LW, 2'd1));
      vecs.push_back(row("dto_exa",  OP_LW, 6'h00, I_NONE, ST_AD, B_NONE, 5'd1, 3'd0, D_LW, 2'd1));
      for (int i = 0; i < 4; i++)
         vecs.push_back(row($sformatf("dto_mem%0d", i), OP_LW, 6'h00, I_NONE, ST_MEM, B_RD, 5'd0, 3'd0, D_LW, 2'd1));
      vecs.push_back(row("dto_trap", OP_LW, 6'h00, I_NONE, ST_TRAP, B_TRAP, 5'd0, 3'd5, D_LW, 2'd3));

      @(negedge clk);
      @(negedge clk);
      #1;
      check_obs("rst_hold_a", obs_a, '0);
      check_obs("rst_hold_b", obs_b, '0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].funct, vecs[i].in);
         #1;
         check_obs(vecs[i].nm, obs_a, vecs[i].exp);
         @(negedge clk);
      end

      // Back in IF after the data timeout trap; reset asynchronously here.
      drive(OP_RTYPE, F_MULT, I_NONE);
      rst = 1'b1;
      #1;
      check_obs("rst_async_a", obs_a, '0);
      @(negedge clk);
      rst = 1'b0;

      drive(OP_RTYPE, F_MULT, I_IA);
      #1;
      check_obs("mult_if", obs_a, mk(ST_IF, B_IFA, 5'd0, 3'd0, D_ADD, 2'd0));
      @(negedge clk);
      drive(OP_RTYPE, F_MULT, I_NONE);
      #1;
      check_obs("mult_id", obs_a, mk(ST_ID, B_MDS, 5'd0, 3'd0, D_ADD, 2'd0));
      check_obs("nomd_id", obs_b, mk(ST_ID, B_NONE, 5'd0, 3'd0, D_ADD, 2'd0));
      @(negedge clk);
      #1;
      check_obs("mult_md0", obs_a, mk(ST_MD, B_NONE, 5'd8, 3'd0, D_ADD, 2'd0));
      check_obs("nomd_trap", obs_b, mk(ST_TRAP, B_TRAP, 5'd0, 3'd5, D_ADD, 2'd1));
      @(negedge clk);
      #1;
      check_obs("mult_md1", obs_a, mk(ST_MD, B_NONE, 5'd8, 3'd0, D_ADD, 2'd0));
      @(negedge clk);
      drive(OP_RTYPE, F_MULT, 5'b00001);
      #1;
      check_obs("mult_done", obs_a, mk(ST_MD, B_NONE, 5'd8, 3'd0, D_ADD, 2'd0));
      @(negedge clk);
      drive(OP_RTYPE, F_MULT, I_NONE);
      #1;
      check_obs("mult_back_if", obs_a, mk(ST_IF, B_IFW, 5'd0, 3'd0, D_ADD, 2'd0));
      @(negedge clk);

      drive(OP_SW, 6'h00, I_IA);
      @(negedge clk);
      drive(OP_SW, 6'h00, I_NONE);
      @(negedge clk);
      @(negedge clk);
      #1;
      check_obs("rst_sw_mem", obs_a, mk(ST_MEM, B_WR, 5'd0, 3'd0, D_SW, 2'd0));
      #2;
      rst = 1'b1;
      #1;
      check_obs("rst_mid_mem_a", obs_a, '0);
      check_obs("rst_mid_mem_b", obs_b, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_obs("post_rst_if", obs_a, mk(ST_IF, B_IFW, 5'd0, 3'd0, D_SW, 2'd0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the MIPS-subset datapath. It decodes op/funct from the instruction register and sequences IF/ID/EX/MEM/WB. It adds three things: req/ack handshakes to instruction and data memory, a multi-cycle multiply/divide wait, and a trap path for illegal opcodes and memory timeouts. It sits between the IR/flag outputs of the datapath and every write-enable and mux select in that datapath.

Parameters:
ALUCTR_W, 5, width of alu_ctr; codes 1=add, 2=sub, 3=or, 4=bgez-compare, 5=and, 6=slt, 7=xor, 8=mult, 9=div, 0=nop
ENABLE_MD, 1, 1 = mult (funct 011000) and div (011010) supported; 0 = both decode as illegal
MEM_TIMEOUT, 16, max cycles waiting for any ack before bus-error trap; 0 disables the timeout
TIMER_W, 5, width of the wait counter; must satisfy 2^TIMER_W > MEM_TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
beqout  in  1  ALU zero flag
bgezout  in  1  ALU sign-clear flag
imem_ack  in  1  instruction memory ack
dmem_ack  in  1  data memory ack
md_done  in  1  mult/div unit complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write, valid with dmem_req
pc_we  out  1  PC write enable
ir_we  out  1  IR write enable
reg_we  out  1  register file write enable
md_start  out  1  one-cycle mult/div start pulse
alu_ctr  out  ALUCTR_W  ALU operation
npc_sel  out  3  0=PC+4, 1=j/jal target, 3=branch target, 4=rs (jr), 5=trap vector
ext_op  out  2  0=lui, 1=zero-extend, 2=sign-extend
regdst_sel  out  2  0=rt, 1=rd, 3=r31
wbsrc_sel  out  3  0=ALU, 1=DM, 2=HI/LO, 3=lui immediate, 4=PC (already incremented)
alusrc_sel  out  1  1=immediate
trap  out  1  asserted for one cycle in state TRAP
cause  out  2  latched trap cause: 0=none, 1=illegal, 2=imem timeout, 3=dmem timeout
state_out  out  4  current state encoding

Behaviour:
- Reset:
  - state = IF, wait counter = 0, cause = 0.
  - While rst is high, every output is 0, including imem_req.
  - After reset deasserts, the first IF cycle drives imem_req = 1.
- All outputs are combinational from state and decode. npc_sel in EX_BR also depends on beqout/bgezout.
- ext_op, regdst_sel, wbsrc_sel and alusrc_sel are driven from decode in every state.
- IF:
  - imem_req = 1; hold in IF until imem_ack.
  - On ack: ir_we = 1, pc_we = 1, npc_sel = 0, go to ID.
- ID:
  - Illegal op/funct -> TRAP, cause = 1.
  - j: pc_we = 1, npc_sel = 1 -> IF.
  - jal: pc_we = 1, npc_sel = 1, reg_we = 1, regdst_sel = 3, wbsrc_sel = 4 -> IF.
  - jr: pc_we = 1, npc_sel = 4 -> IF.
  - lw/sw -> EX_ADDR.
  - beq/bgez/bgtz -> EX_BR.
  - mult/div -> EX_MD with md_start = 1 for exactly one cycle.
  - All other legal instructions -> EX.
- EX: alu_ctr per op -> WB_ALU.
- WB_ALU: reg_we = 1 -> IF. alu_ctr is 0 in every state outside EX, EX_ADDR, EX_BR and EX_MD.
- EX_BR:
  - alu_ctr = 2 for beq, 4 for bgez/bgtz.
  - Taken if (beq & beqout) | (bgez & bgezout) | (bgtz & bgezout & !beqout).
  - Taken: pc_we = 1, npc_sel = 3. Not taken: no PC write.
  - -> IF.
- EX_ADDR: alu_ctr = 1, alusrc_sel = 1, ext_op = 2 -> MEM.
- MEM:
  - dmem_req = 1; dmem_we = sw.
  - Hold until dmem_ack. On ack: lw -> WB_MEM, sw -> IF.
- WB_MEM: reg_we = 1, wbsrc_sel = 1, regdst_sel = 0 -> IF.
- EX_MD: alu_ctr = 8 or 9; hold until md_done -> IF. There is no register write; HI/LO are written inside the multiply/divide unit.
- Wait counter:
  - Cleared on entry to IF or MEM; increments each cycle without ack.
  - If MEM_TIMEOUT > 0 and counter == MEM_TIMEOUT-1 with no ack in that cycle -> TRAP. cause = 2 from IF, 3 from MEM.
  - An ack arriving in the same cycle as the timeout wins, and the normal transition is taken.
  - EX_MD has no timeout.
- TRAP:
  - trap = 1, pc_we = 1, npc_sel = 5, no register or memory write -> IF.
  - cause holds until the next trap or reset.
- Requests stay asserted while waiting. The memory may ack in the same cycle the request is raised, giving a zero-wait transfer.
- Asynchronous reset in any state, including mid-MEM: dmem_req drops immediately and no partial write is issued by the FSM.
- State encodings:
  - IF=0, ID=1, EX=2, EX_BR=3, EX_ADDR=4, MEM=5, WB_ALU=6, WB_MEM=7, EX_MD=8, TRAP=9.
  - Unused encodings -> IF.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode and funct constants;
  - state encodings;
  - alu_ctr, npc_sel, wbsrc_sel and cause codes.
- One sub-module, mc_decode: purely combinational op/funct -> instruction class, illegal flag, ext_op, regdst_sel, wbsrc_sel, alusrc_sel and EX alu_ctr.
- The FSM, wait counter and cause register stay in mc_ctrl_fsm.

Test Plan:
- add (op 0, funct 0x20), imem_ack after 2 wait cycles -> states IF,IF,IF,ID,EX,WB_ALU; alu_ctr = 1 in EX; reg_we = 1 only in WB_ALU; regdst_sel = 1.
- lw with dmem_ack on the first MEM cycle -> IF,ID,EX_ADDR,MEM,WB_MEM; dmem_req = 1, dmem_we = 0 in MEM; wbsrc_sel = 1 with reg_we = 1 in WB_MEM.
- sw, then beq twice (beqout = 1, then beqout = 0) -> sw: dmem_we = 1 in MEM, then IF with no reg_we. First beq: pc_we = 1, npc_sel = 3 in EX_BR. Second beq: pc_we = 0.
- jal -> pc_we = 1, npc_sel = 1, reg_we = 1, regdst_sel = 3, wbsrc_sel = 4 in ID; next state IF.
- MEM_TIMEOUT = 4: imem_ack held low -> TRAP after 4 IF cycles, cause = 2, npc_sel = 5. Repeat with ack in cycle 4 -> goes to ID, no trap.
- op 0x3F -> TRAP with cause = 1. With ENABLE_MD = 0, mult also -> TRAP. With ENABLE_MD = 1, mult -> md_start single pulse, stays in EX_MD until md_done. Then assert rst mid-MEM -> all outputs 0 immediately, state_out = 0.
